// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH free-running 50%-duty clock dividers (half-period HALF_BASE<<i) plus a
// glitch-free output selector. Optional macro CLK_DIV_BANK_GATE_EN adds per-channel enable ch_en.
module clk_div_bank #(
   parameter  int NUM_CH    = 4,
   parameter  int HALF_BASE = 2,
   parameter  int CNT_W     = 16,
   localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] key,
`ifdef CLK_DIV_BANK_GATE_EN
   input  logic [NUM_CH-1:0] ch_en,
`endif
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic              sel_out,
   output logic [SEL_W-1:0]  sel_idx,
   output logic              busy,
   output logic              dbg_state
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   logic [NUM_CH-1:0] w_en;
   logic [NUM_CH-1:0] w_clk_out;
   logic [NUM_CH-1:0] w_tick;

`ifdef CLK_DIV_BANK_GATE_EN
   assign w_en = ch_en;
`else
   assign w_en = '1;
`endif

   // Every channel counts from the same reset release, so all dividers stay phase-aligned.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [CNT_W-1:0] LIM = CNT_W'((HALF_BASE << g) - 1);

      logic [CNT_W-1:0] r_cnt;
      logic             r_clk;
      logic             r_tick;

      always_ff @(posedge clk) begin
         if (rst || !w_en[g]) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
         end else if (r_cnt == LIM) begin
            r_cnt  <= '0;
            r_clk  <= ~r_clk;
            r_tick <= ~r_clk;
         end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
         end
      end

      assign w_clk_out[g] = r_clk;
      assign w_tick[g]    = r_tick;
   end

   logic             w_key_valid;
   logic [SEL_W-1:0] w_key_idx;
   logic [SEL_W-1:0] w_tgt;

   always_comb begin
      w_key_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (key[i]) w_key_idx = SEL_W'(i);
      end
   end

   assign w_key_valid = (key != '0) && ((key & (key - NUM_CH'(1))) == '0);

   state_t           r_state;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] r_pend;
   logic             r_busy;

   // A key arriving in WAIT retargets the switch in the same cycle, so a held key still completes.
   assign w_tgt = w_key_valid ? w_key_idx : r_pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
         r_sel   <= '0;
         r_pend  <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_key_valid && (w_key_idx != r_sel)) begin
                  r_pend  <= w_key_idx;
                  r_state <= S_WAIT;
                  r_busy  <= 1'b1;
               end
            end
            S_WAIT: begin
               if (w_key_valid && (w_key_idx == r_sel)) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b0;
               end else begin
                  r_pend <= w_tgt;
                  // Switch only while both sources are low so sel_out never shows a runt pulse.
                  if (!w_clk_out[r_sel] && !w_clk_out[w_tgt]) begin
                     r_sel   <= w_tgt;
                     r_state <= S_RUN;
                     r_busy  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign clk_out   = w_clk_out;
   assign tick      = w_tick;
   assign sel_out   = w_clk_out[r_sel];
   assign sel_idx   = r_sel;
   assign busy      = r_busy;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank (NUM_CH=4, HALF_BASE=2): hand tables, directed corner sequences and
// random key/reset traffic against a cycle-count based reference model.
module tb_clk_div_bank;

   localparam int NCH = 4;
   localparam int HB  = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NCH-1:0] key = '0;
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] tick;
   logic           sel_out;
   logic [1:0]     sel_idx;
   logic           busy;
   logic           dbg_state;
`ifdef CLK_DIV_BANK_GATE_EN
   logic [NCH-1:0] ch_en = '1;
`endif

   clk_div_bank #(.NUM_CH(NCH), .HALF_BASE(HB), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
`ifdef CLK_DIV_BANK_GATE_EN
      .ch_en     (ch_en),
`endif
      .clk_out   (clk_out),
      .tick      (tick),
      .sel_out   (sel_out),
      .sel_idx   (sel_idx),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model: n = rising edges since reset release, plus selection bookkeeping
   int             m_n    = 0;
   int             m_sel  = 0;
   int             m_pend = 0;
   bit             m_busy = 0;
   logic [NCH-1:0] m_en   = '1;
   int             hi_run = 0;

   function automatic bit mclk(input int i, input int n);
      if (!m_en[i]) return 1'b0;
      return ((n / (HB << i)) % 2) == 1;
   endfunction

   function automatic bit mtick(input int i, input int n);
      int h;
      h = HB << i;
      if (!m_en[i]) return 1'b0;
      return (n >= h) && ((n % (2 * h)) == h);
   endfunction

   function automatic int idx_of(input logic [NCH-1:0] k);
      int r;
      r = 0;
      for (int i = 0; i < NCH; i++) if (k[i]) r = i;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic [NCH-1:0] k, input logic r);
      bit kv;
      int ki;
      int tgt;
      if (r) begin
         m_n = 0; m_sel = 0; m_pend = 0; m_busy = 0;
         return;
      end
      kv = ($countones(k) == 1);
      ki = idx_of(k);
      if (!m_busy) begin
         if (kv && ki != m_sel) begin
            m_pend = ki;
            m_busy = 1;
         end
      end else if (kv && ki == m_sel) begin
         m_busy = 0;
      end else begin
         tgt = kv ? ki : m_pend;
         m_pend = tgt;
         if (!mclk(m_sel, m_n) && !mclk(tgt, m_n)) begin
            m_sel  = tgt;
            m_busy = 0;
         end
      end
      m_n++;
   endtask

   task automatic compare_all();
      logic [NCH-1:0] ec;
      logic [NCH-1:0] et;
      for (int i = 0; i < NCH; i++) begin
         ec[i] = mclk(i, m_n);
         et[i] = mtick(i, m_n);
      end
      chk("clk_out", 32'(clk_out), 32'(ec));
      chk("tick", 32'(tick), 32'(et));
      chk("sel_idx", 32'(sel_idx), 32'(m_sel));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("dbg_state", 32'(dbg_state), 32'(m_busy));
      chk("sel_out", 32'(sel_out), 32'(mclk(m_sel, m_n)));
      if (sel_out === 1'b1) begin
         hi_run++;
      end else if (hi_run > 0) begin
         chk("sel_out_min_high", 32'(hi_run >= HB), 32'd1);
         hi_run = 0;
      end
   endtask

   task automatic step(input logic [NCH-1:0] k, input logic r);
      key = k;
      rst = r;
      @(posedge clk);
      model_edge(k, r);
      #1;
      if (r) hi_run = 0;
      compare_all();
   endtask

   typedef struct {
      int             n;
      logic [NCH-1:0] exp_clk;
      logic [NCH-1:0] exp_tick;
   } vec_t;

   vec_t vtab[11];

   initial begin
      logic [NCH-1:0] prev;
      logic [NCH-1:0] rk;
      int             cnt;

      vtab[0]  = '{1,  4'b0000, 4'b0000};
      vtab[1]  = '{2,  4'b0001, 4'b0001};
      vtab[2]  = '{3,  4'b0001, 4'b0000};
      vtab[3]  = '{4,  4'b0010, 4'b0010};
      vtab[4]  = '{6,  4'b0011, 4'b0001};
      vtab[5]  = '{8,  4'b0100, 4'b0100};
      vtab[6]  = '{12, 4'b0110, 4'b0010};
      vtab[7]  = '{16, 4'b1000, 4'b1000};
      vtab[8]  = '{32, 4'b0000, 4'b0000};
      vtab[9]  = '{34, 4'b0001, 4'b0001};
      vtab[10] = '{48, 4'b1000, 4'b1000};

      #1;
      for (int i = 0; i < 3; i++) step('0, 1'b1);

      for (int v = 0; v < 11; v++) begin
         while (m_n < vtab[v].n) step('0, 1'b0);
         chk("tab_clk_out", 32'(clk_out), 32'(vtab[v].exp_clk));
         chk("tab_tick", 32'(tick), 32'(vtab[v].exp_tick));
      end

      // invalid keys are ignored
      for (int i = 0; i < 4; i++) step(4'b0110, 1'b0);
      chk("multihot_busy", 32'(busy), 32'd0);
      chk("multihot_sel", 32'(sel_idx), 32'd0);
      for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
      chk("same_key_busy", 32'(busy), 32'd0);

      // switch 0 -> 1 with key held
      step(4'b0010, 1'b0);
      chk("sw01_busy_rise", 32'(busy), 32'd1);
      cnt = 0;
      prev = clk_out;
      while (busy === 1'b1 && cnt < 40) begin
         prev = clk_out;
         step(4'b0010, 1'b0);
         cnt++;
      end
      chk("sw01_sel", 32'(sel_idx), 32'd1);
      chk("sw01_latency", 32'(cnt + 1 <= 33), 32'd1);
      chk("sw01_both_low", 32'(prev[1:0]), 32'd0);

      // retarget during WAIT: pending 2 overwritten by 3
      step(4'b0100, 1'b0);
      chk("sw13_busy_rise", 32'(busy), 32'd1);
      step(4'b1000, 1'b0);
      cnt = 1;
      while (busy === 1'b1 && cnt < 40) begin
         step('0, 1'b0);
         cnt++;
      end
      chk("sw13_sel", 32'(sel_idx), 32'd3);
      chk("sw13_latency", 32'(cnt <= 33), 32'd1);

      // cancel: WAIT toward 0, then key back to current selection
      step(4'b0001, 1'b0);
      chk("cancel_busy_rise", 32'(busy), 32'd1);
      step(4'b1000, 1'b0);
      chk("cancel_busy", 32'(busy), 32'd0);
      chk("cancel_sel", 32'(sel_idx), 32'd3);

      // reset during WAIT toward channel 2; key ignored under reset
      step(4'b0100, 1'b0);
      chk("rstwait_busy_rise", 32'(busy), 32'd1);
      step(4'b0100, 1'b1);
      chk("rstwait_sel", 32'(sel_idx), 32'd0);
      chk("rstwait_busy", 32'(busy), 32'd0);
      chk("rstwait_clk_out", 32'(clk_out), 32'd0);
      chk("rstwait_sel_out", 32'(sel_out), 32'd0);

      // random traffic
      rk = '0;
      for (int c = 0; c < 1500; c++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: rk = '0;
            5, 6, 7:       rk = NCH'(1) << $urandom_range(0, NCH - 1);
            8:             rk = NCH'($urandom_range(0, 15));
            default:       rk = rk;
         endcase
         step(rk, ($urandom_range(0, 199) == 0));
      end

`ifdef CLK_DIV_BANK_GATE_EN
      ch_en = 4'b1011;
      m_en  = 4'b1011;
      step('0, 1'b1);
      for (int i = 0; i < 20; i++) step('0, 1'b0);
      chk("gate_ch2_low", 32'(clk_out[2]), 32'd0);
      step(4'b0100, 1'b0);
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         step('0, 1'b0);
         cnt++;
      end
      chk("gate_sel", 32'(sel_idx), 32'd2);
      chk("gate_latency", 32'(cnt <= 2), 32'd1);
      for (int i = 0; i < 10; i++) step('0, 1'b0);
      chk("gate_sel_out", 32'(sel_out), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
